// File: rtl/led_heartbeat.sv
// rtl/led_heartbeat.sv - LED heartbeat: reset synchroniser, tick prescaler, blink phase and shared PWM.
// Each channel selects OFF, ON, BLINK or DIM from a 2-bit mode field.
module led_heartbeat #(
  parameter int NCH         = 4,
  parameter int DIV         = 16000000,
  parameter int SYNC_STAGES = 2,
  parameter int PWM_BITS    = 8
) (
  input  logic                  pixel_clk,
  input  logic                  sys_rst,
  input  logic [2*NCH-1:0]      mode,
  input  logic [PWM_BITS-1:0]   duty,
  output logic                  pixel_rst,
  output logic                  tick,
  output logic [NCH-1:0]        led
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_DIM   = 2'b11;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [CW-1:0]          cnt;
  logic                   phase;
  logic [PWM_BITS-1:0]    pwm_cnt;
  logic                   cnt_last;
  logic                   pwm_on;

  // Assert immediately, release only after the chain has flushed to zero.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rst_sync <= '1;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign pixel_rst = rst_sync[SYNC_STAGES-1];

  assign cnt_last = (cnt == CNT_MAX);
  assign pwm_on   = (pwm_cnt < duty);

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      phase   <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      cnt     <= cnt_last ? '0 : cnt + 1'b1;
      tick    <= cnt_last;
      phase   <= phase ^ cnt_last;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Odd channels blink in antiphase so neighbouring LEDs alternate.
    localparam logic ODD = ((c % 2) == 1);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
        led[c] <= 1'b0;
      end else begin
        case (mode[2*c +: 2])
          MODE_OFF:   led[c] <= 1'b0;
          MODE_ON:    led[c] <= 1'b1;
          MODE_BLINK: led[c] <= phase ^ ODD;
          MODE_DIM:   led[c] <= pwm_on;
          default:    led[c] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_heartbeat.sv
// tb/tb_led_heartbeat.sv - self-checking bench for led_heartbeat against an edge-count reference model.
module tb_led_heartbeat;

  localparam int NCH = 4;
  localparam int DIV = 4;
  localparam int SS  = 2;
  localparam int PB  = 4;

  logic              pixel_clk;
  logic              sys_rst;
  logic [2*NCH-1:0]  mode;
  logic [PB-1:0]     duty;
  logic              pixel_rst;
  logic              tick;
  logic [NCH-1:0]    led;

  int n_vec = 0;
  int n_err = 0;
  int k     = 0;
  bit in_rst = 1'b1;

  led_heartbeat #(.NCH(NCH), .DIV(DIV), .SYNC_STAGES(SS), .PWM_BITS(PB)) dut (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .mode      (mode),
    .duty      (duty),
    .pixel_rst (pixel_rst),
    .tick      (tick),
    .led       (led)
  );

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  // led after the kk-th edge since release reflects the phase and PWM count
  // that held during edge kk-1.
  function automatic logic [NCH-1:0] model_led(int kk, logic [2*NCH-1:0] m, logic [PB-1:0] d);
    logic [NCH-1:0] r;
    int ph;
    int pc;
    r = '0;
    if (kk <= 0) return r;
    ph = ((kk - 1) / DIV) % 2;
    pc = (kk - 1) % (1 << PB);
    for (int c = 0; c < NCH; c++) begin
      case (m[2*c +: 2])
        2'b00: r[c] = 1'b0;
        2'b01: r[c] = 1'b1;
        2'b10: r[c] = ((ph + c) % 2) == 1;
        default: r[c] = pc < int'(d);
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
    if (in_rst) begin
      chk("rst_pixel_rst", 32'(pixel_rst), 32'd1);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_led", 32'(led), 32'd0);
    end else begin
      k++;
      chk("pixel_rst", 32'(pixel_rst), 32'd0);
      chk("tick", 32'(tick), 32'((k > 0) && (k % DIV == 0)));
      chk("led", 32'(led), 32'(model_led(k, mode, duty)));
    end
  endtask

  task automatic release_reset();
    #2 sys_rst = 1'b0;
    @(posedge pixel_clk);
    #1;
    chk("rel_edge1_pixel_rst", 32'(pixel_rst), 32'd1);
    chk("rel_edge1_led", 32'(led), 32'd0);
    @(posedge pixel_clk);
    #1;
    chk("rel_edge2_pixel_rst", 32'(pixel_rst), 32'd0);
    chk("rel_edge2_tick", 32'(tick), 32'd0);
    chk("rel_edge2_led", 32'(led), 32'd0);
    k = 0;
    in_rst = 1'b0;
  endtask

  initial begin
    int ticks;
    int lit;
    logic [PB-1:0] duties [3];

    sys_rst = 1'b0;
    mode    = '0;
    duty    = '0;
    #2 sys_rst = 1'b1;
    #1;
    chk("por_pixel_rst", 32'(pixel_rst), 32'd1);

    // Outputs stay at reset whatever mode and duty are applied.
    for (int i = 0; i < 4; i++) begin
      mode = 8'($urandom);
      duty = 4'($urandom);
      step();
    end

    mode = '0;
    duty = '0;
    release_reset();

    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick === 1'b1) ticks++;
    end
    chk("tick_count_40", 32'(ticks), 32'd10);

    mode = 8'b10101010;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("blink_antiphase", 32'(led[1] ^ led[0]), 32'd1);
    end

    // Asynchronous reset pulse mid-cycle with LEDs lit.
    mode = 8'b01010101;
    step();
    chk("all_on", 32'(led), 32'hF);
    #2 sys_rst = 1'b1;
    #1;
    in_rst = 1'b1;
    chk("pulse_pixel_rst", 32'(pixel_rst), 32'd1);
    chk("pulse_led", 32'(led), 32'd0);
    chk("pulse_tick", 32'(tick), 32'd0);
    step();
    mode = 8'b10101010;
    release_reset();

    for (int i = 1; i <= 8; i++) begin
      step();
      if (i <= 4) chk("blink_first", 32'(led), 32'b1010);
      else chk("blink_second", 32'(led), 32'b0101);
    end

    duties[0] = 4'd4;
    duties[1] = 4'd0;
    duties[2] = 4'd15;
    for (int j = 0; j < 3; j++) begin
      mode = {6'($urandom), 2'b11};
      duty = duties[j];
      lit  = 0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (led[0] === 1'b1) lit++;
      end
      chk("dim_lit_count", 32'(lit), 32'(duties[j]));
    end

    mode = 8'b00_11_10_01;
    step();
    chk("static_ch3_off", 32'(led[3]), 32'd0);
    mode[7:6] = 2'b01;
    step();
    chk("static_ch3_on", 32'(led[3]), 32'd1);

    // Reset mid-operation in BLINK with the prescaler at 2.
    mode = 8'b10101010;
    for (int i = 0; i < DIV && (k % DIV) != 2; i++) step();
    chk("cnt_at_2", 32'(k % DIV), 32'd2);
    #2 sys_rst = 1'b1;
    #1;
    in_rst = 1'b1;
    chk("mid_pixel_rst", 32'(pixel_rst), 32'd1);
    chk("mid_led", 32'(led), 32'd0);
    chk("mid_tick", 32'(tick), 32'd0);
    step();
    step();
    release_reset();
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("mid_first_tick", 32'(tick), 32'(i == 4 || i == 8));
    end

    for (int i = 0; i < 300; i++) begin
      mode = 8'($urandom);
      duty = 4'($urandom_range(0, 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
